// File: rtl/add_round_key_stage_if.sv
// Valid/ready stream bundle for the AddRoundKey stage: state rows in, keyed rows out.
// The slave modport is the stage's view; master is the producer/consumer side.
interface add_round_key_stage_if #(
    parameter int unsigned RW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic          in_first;
    logic [31:0]   line0;
    logic [31:0]   line1;
    logic [31:0]   line2;
    logic [31:0]   line3;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   outline0;
    logic [31:0]   outline1;
    logic [31:0]   outline2;
    logic [31:0]   outline3;
    logic [RW-1:0] out_round;
    logic          out_last;

    modport slave (
        input  in_valid, in_first, line0, line1, line2, line3, out_ready,
        output in_ready, out_valid, outline0, outline1, outline2, outline3, out_round, out_last
    );

    modport master (
        output in_valid, in_first, line0, line1, line2, line3, out_ready,
        input  in_ready, out_valid, outline0, outline1, outline2, outline3, out_round, out_last
    );
endinterface

// File: rtl/add_round_key_stage.sv
// Registered AddRoundKey stage: fetches the round key from a synchronous key store,
// XORs it into the four row lines and tracks the round index across a block.
module add_round_key_stage #(
    parameter int unsigned NR = 10,
    parameter int unsigned RW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    add_round_key_stage_if.slave bus,
    output logic [RW-1:0]        rk_addr,
    input  logic [127:0]         rk_data,
    output logic                 err_seq
);
    localparam logic [RW-1:0] NrL = RW'(NR);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StOut} state_e;

    state_e              state_q, state_d;
    logic [3:0][31:0]    line_q, line_d;
    logic [3:0][31:0]    outline_q, outline_d;
    logic [RW-1:0]       rk_addr_q, rk_addr_d;
    logic [RW-1:0]       round_cnt_q, round_cnt_d;
    logic [RW-1:0]       out_round_q, out_round_d;
    logic                out_last_q, out_last_d;
    logic                err_q, err_d;
    logic [RW-1:0]       round;
    logic                seq_err;
    logic                accept;

    assign bus.in_ready = (state_q == StIdle) | ((state_q == StOut) & bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;

    // A continuation beat with no block in progress restarts at round 0 and flags it.
    always_comb begin
        seq_err = 1'b0;
        if (bus.in_first) begin
            round = '0;
        end else if (round_cnt_q < NrL) begin
            round = round_cnt_q + RW'(1);
        end else begin
            round   = '0;
            seq_err = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        outline_d   = outline_q;
        rk_addr_d   = rk_addr_q;
        round_cnt_d = round_cnt_q;
        out_round_d = out_round_q;
        out_last_d  = out_last_q;
        err_d       = 1'b0;

        if (accept) begin
            line_d[0]   = bus.line0;
            line_d[1]   = bus.line1;
            line_d[2]   = bus.line2;
            line_d[3]   = bus.line3;
            rk_addr_d   = round;
            round_cnt_d = round;
            err_d       = seq_err;
        end

        unique case (state_q)
            StIdle: if (accept) state_d = StAddr;
            StAddr: state_d = StData;
            StData: begin
                // Key words are columns; row R of column c sits at byte R of word c.
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        outline_d[r][31-8*c -: 8] = line_q[r][31-8*c -: 8]
                                                    ^ rk_data[127-32*c-8*r -: 8];
                    end
                end
                out_round_d = rk_addr_q;
                out_last_d  = (rk_addr_q == NrL);
                state_d     = StOut;
            end
            StOut: if (bus.out_ready) state_d = bus.in_valid ? StAddr : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            line_q      <= '0;
            outline_q   <= '0;
            rk_addr_q   <= '0;
            round_cnt_q <= NrL;
            out_round_q <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            outline_q   <= outline_d;
            rk_addr_q   <= rk_addr_d;
            round_cnt_q <= round_cnt_d;
            out_round_q <= out_round_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    assign bus.out_valid = (state_q == StOut);
    assign bus.outline0  = outline_q[0];
    assign bus.outline1  = outline_q[1];
    assign bus.outline2  = outline_q[2];
    assign bus.outline3  = outline_q[3];
    assign bus.out_round = out_round_q;
    assign bus.out_last  = out_last_q;
    assign rk_addr       = rk_addr_q;
    assign err_seq       = err_q;
endmodule

// File: tb/tb_add_round_key_stage.sv
// Directed bench for add_round_key_stage: table of beats through a full key schedule,
// plus hand-written backpressure and mid-beat reset sequences.
module tb_add_round_key_stage;
    typedef struct packed {
        logic             first;
        logic [3:0][31:0] line;
        logic [3:0][31:0] exp;
        logic [3:0]       rnd;
        logic             last;
        logic             err;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
    logic         err_seq;
    logic [127:0] rk_mem [16];
    vec_t         vecs [12];
    int           n_chk;
    int           n_pass;

    add_round_key_stage_if #(.RW(4)) bus ();

    add_round_key_stage #(.NR(10), .RW(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .rk_addr (rk_addr),
        .rk_data (rk_data),
        .err_seq (err_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read key store.
    always @(posedge clk) rk_data <= rk_mem[rk_addr];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_out(input vec_t v);
        chk("out_valid", 128'(bus.out_valid), 128'(1'b1));
        chk("outline0", 128'(bus.outline0), 128'(v.exp[0]));
        chk("outline1", 128'(bus.outline1), 128'(v.exp[1]));
        chk("outline2", 128'(bus.outline2), 128'(v.exp[2]));
        chk("outline3", 128'(bus.outline3), 128'(v.exp[3]));
        chk("out_round", 128'(bus.out_round), 128'(v.rnd));
        chk("out_last", 128'(bus.out_last), 128'(v.last));
    endtask

    task automatic drive(input vec_t v);
        bus.in_valid = 1'b1;
        bus.in_first = v.first;
        bus.line0    = v.line[0];
        bus.line1    = v.line[1];
        bus.line2    = v.line[2];
        bus.line3    = v.line[3];
    endtask

    // After the accept edge: ADDR, DATA, then OUT observed on successive negedges.
    task automatic follow(input vec_t v);
        @(negedge clk);
        chk("rk_addr", 128'(rk_addr), 128'(v.rnd));
        chk("err_seq_addr", 128'(err_seq), 128'(v.err));
        chk("out_valid_addr", 128'(bus.out_valid), 128'(1'b0));
        @(negedge clk);
        chk("out_valid_data", 128'(bus.out_valid), 128'(1'b0));
        chk("err_seq_data", 128'(err_seq), 128'(1'b0));
        @(negedge clk);
        check_out(v);
        chk("err_seq_out", 128'(err_seq), 128'(1'b0));
    endtask

    task automatic beat(input vec_t v);
        @(negedge clk);
        drive(v);
        chk("in_ready_idle", 128'(bus.in_ready), 128'(1'b1));
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        follow(v);
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk("out_valid_idle", 128'(bus.out_valid), 128'(1'b0));
    endtask

    initial begin
        logic [7:0] kb;
        vec_t       v;
        n_chk  = 0;
        n_pass = 0;

        for (int i = 0; i < 16; i++) rk_mem[i] = '0;
        rk_mem[0] = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
        rk_mem[1] = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;

        vecs[0] = '0;
        vecs[0].first  = 1'b1;
        vecs[0].exp[0] = 32'h2b28ab09;
        vecs[0].exp[1] = 32'h7eaef7cf;
        vecs[0].exp[2] = 32'h15d2154f;
        vecs[0].exp[3] = 32'h16a6883c;

        vecs[1] = '0;
        vecs[1].line[0] = 32'h04e04828;
        vecs[1].line[1] = 32'h66cbf806;
        vecs[1].line[2] = 32'h8119d326;
        vecs[1].line[3] = 32'he59a7a4c;
        vecs[1].exp[0]  = 32'ha4686b02;
        vecs[1].exp[1]  = 32'h9c9f5b6a;
        vecs[1].exp[2]  = 32'h7f35ea50;
        vecs[1].exp[3]  = 32'hf22b4349;
        vecs[1].rnd     = 4'd1;

        // Rounds 2..10: uniform key bytes r*0x11 against all-ones lines.
        for (int r = 2; r <= 10; r++) begin
            kb = 8'(r * 17);
            rk_mem[r] = {16{kb}};
            vecs[r] = '0;
            for (int k = 0; k < 4; k++) begin
                vecs[r].line[k] = 32'hffffffff;
                vecs[r].exp[k]  = {4{~kb}};
            end
            vecs[r].rnd  = 4'(r);
            vecs[r].last = (r == 10);
        end

        // Continuation beat after the last round: restarts at round 0 with an error.
        vecs[11]     = vecs[0];
        vecs[11].first = 1'b0;
        vecs[11].err   = 1'b1;

        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.line0     = '0;
        bus.line1     = '0;
        bus.line2     = '0;
        bus.line3     = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        chk("rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1'b1));
        chk("rst_rk_addr", 128'(rk_addr), 128'(4'd0));
        chk("rst_out_round", 128'(bus.out_round), 128'(4'd0));
        chk("rst_out_last", 128'(bus.out_last), 128'(1'b0));
        chk("rst_err_seq", 128'(err_seq), 128'(1'b0));
        chk("rst_outlines", {bus.outline0, bus.outline1, bus.outline2, bus.outline3}, 128'd0);

        for (int i = 0; i < 12; i++) begin
            beat(vecs[i]);
            drain();
        end

        // Backpressure: outputs frozen, in_ready low while a new beat waits.
        beat(vecs[0]);
        v = vecs[1];
        drive(v);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_out(vecs[0]);
            chk("in_ready_stall", 128'(bus.in_ready), 128'(1'b0));
        end
        bus.out_ready = 1'b1;
        #1 chk("in_ready_release", 128'(bus.in_ready), 128'(1'b1));
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        follow(v);
        drain();

        // Reset during DATA: the beat in flight never emerges.
        v = vecs[2];
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
        chk("mid_rst_rk_addr", 128'(rk_addr), 128'(4'd0));
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_quiet", 128'(bus.out_valid), 128'(1'b0));
        end
        bus.out_ready = 1'b0;
        beat(vecs[11]);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
